ar_txd: RTL and testbench

- ARINC-429-style serial word transmitter; the transmit end of the RXD0/RXD1 bipolar return-to-zero line pair.
- Accepts an 8-bit label and 23-bit data word from the host with a single-cycle strobe.
- Appends odd parity and serialises 32 bits as RZ pulses on TXD1/TXD0.
- After the word, enforces an inter-word null gap before accepting the next word.

---
 rtl/ar429_pkg.sv | 35 +++
 rtl/ar_bit_tick.sv | 37 +++
 rtl/ar_txd.sv | 132 +++++++++++++
 tb/tb_ar_txd.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ar429_pkg.sv
// Shared constants, state encoding and word-packing helpers for the ARINC-429 style transmitter.
// Optional feature macro used by the top: AR_TXD_PAR_ERR_EN (forced even parity for error-path tests).
package ar429_pkg;

  localparam int WORD_BITS  = 32;
  localparam int LABEL_BITS = 8;
  localparam int DATA_BITS  = 23;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    GAP  = 2'd3
  } txd_state_e;

  // Odd parity over label and data: the complete 32-bit word carries an odd number of ones.
  function automatic logic odd_par(input logic [LABEL_BITS-1:0] label,
                                   input logic [DATA_BITS-1:0]  data);
    return ~(^label ^ ^data);
  endfunction

  // Packs the word so that bit 31 goes out first: label MSB-first, data LSB-first, then parity.
  function automatic logic [WORD_BITS-1:0] pack_word(input logic [LABEL_BITS-1:0] label,
                                                     input logic [DATA_BITS-1:0]  data,
                                                     input logic                  par);
    logic [WORD_BITS-1:0] w;
    w[WORD_BITS-1 -: LABEL_BITS] = label;
    for (int i = 0; i < DATA_BITS; i++) begin
      w[WORD_BITS-1-LABEL_BITS-i] = data[i];
    end
    w[0] = par;
    return w;
  endfunction

endpackage

// File: rtl/ar_bit_tick.sv
// Half-bit tick generator: counts 0..H-1 while enabled, pulses tick_o on the last count.
// A synchronous clear restarts the count from zero so every word starts phase-aligned.
module ar_bit_tick #(
  parameter int H = 250
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int            CW   = (H > 1) ? $clog2(H) : 1;
  localparam logic [CW-1:0] LAST = CW'(H - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = en_i && !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/ar_txd.sv
// ARINC-429 style word transmitter: 32 bipolar RZ bits on TXD1/TXD0, then an inter-word null gap.
// Define AR_TXD_PAR_ERR_EN to add the par_err input that inverts the parity bit of a word.
module ar_txd
  import ar429_pkg::*;
#(
  parameter int CLK_HZ   = 50_000_000,
  parameter int BIT_HZ   = 100_000,
  parameter int GAP_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [LABEL_BITS-1:0] in_adr,
  input  logic [DATA_BITS-1:0]  in_dat,
  input  logic                  st,
`ifdef AR_TXD_PAR_ERR_EN
  input  logic                  par_err,
`endif
  output logic                  TXD1,
  output logic                  TXD0,
  output logic                  rdy,
  output logic                  ce_end
);

  localparam int            H        = CLK_HZ / BIT_HZ / 2;
  localparam int            GW       = (2 * GAP_BITS > 1) ? $clog2(2 * GAP_BITS) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(2 * GAP_BITS - 1);
  localparam logic [4:0]    IDX_LAST = 5'(WORD_BITS - 1);

  txd_state_e           state_q, state_d;
  logic [WORD_BITS-1:0] shift_q, shift_d;
  logic [4:0]           idx_q, idx_d;
  logic [GW-1:0]        gap_q, gap_d;
  logic                 txd1_q, txd1_d;
  logic                 txd0_q, txd0_d;
  logic                 accept;
  logic                 tick;
  logic                 par_bit;

`ifdef AR_TXD_PAR_ERR_EN
  assign par_bit = odd_par(in_adr, in_dat) ^ par_err;
`else
  assign par_bit = odd_par(in_adr, in_dat);
`endif

  ar_bit_tick #(
    .H(H)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (accept),
    .en_i  (state_q != IDLE),
    .tick_o(tick)
  );

  // Each bit is a HIGH half followed by a LOW half; the gap is counted in half-bit ticks.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    accept  = 1'b0;
    ce_end  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (st) begin
          accept  = 1'b1;
          shift_d = pack_word(in_adr, in_dat, par_bit);
          idx_d   = '0;
          gap_d   = '0;
          state_d = HIGH;
        end
      end
      HIGH: begin
        if (tick) begin
          state_d = LOW;
        end
      end
      LOW: begin
        if (tick) begin
          if (idx_q != IDX_LAST) begin
            idx_d   = idx_q + 5'd1;
            shift_d = {shift_q[WORD_BITS-2:0], 1'b0};
            state_d = HIGH;
          end else begin
            gap_d   = '0;
            state_d = GAP;
          end
        end
      end
      GAP: begin
        if (tick) begin
          if (gap_q == GAP_LAST) begin
            ce_end  = 1'b1;
            state_d = IDLE;
          end else begin
            gap_d = gap_q + GW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Lines are registered from the next state so they align exactly with the HIGH half-bits.
  always_comb begin
    txd1_d = (state_d == HIGH) &&  shift_d[WORD_BITS-1];
    txd0_d = (state_d == HIGH) && !shift_d[WORD_BITS-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      gap_q   <= '0;
      txd1_q  <= 1'b0;
      txd0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      txd1_q  <= txd1_d;
      txd0_q  <= txd0_d;
    end
  end

  assign TXD1 = txd1_q;
  assign TXD0 = txd0_q;
  assign rdy  = (state_q == IDLE);

endmodule

// File: tb/tb_ar_txd.sv
// Randomised self-checking bench for ar_txd, compared every cycle against a timeline model
// that derives line levels from the time elapsed since each accepted word.
module tb_ar_txd;

  localparam int CLK_HZ   = 50_000_000;
  localparam int BIT_HZ   = 1_000_000;
  localparam int GAP_BITS = 4;
  localparam int H        = CLK_HZ / BIT_HZ / 2;
  localparam int BITT     = 2 * H;
  localparam int TOTAL    = (32 + GAP_BITS) * BITT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_adr = '0;
  logic [22:0] in_dat = '0;
  logic        st = 1'b0;
  logic        par_err_s = 1'b0;
  logic        TXD1, TXD0, rdy, ce_end;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ar_txd #(
    .CLK_HZ  (CLK_HZ),
    .BIT_HZ  (BIT_HZ),
    .GAP_BITS(GAP_BITS)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .in_adr (in_adr),
    .in_dat (in_dat),
    .st     (st),
`ifdef AR_TXD_PAR_ERR_EN
    .par_err(par_err_s),
`endif
    .TXD1   (TXD1),
    .TXD0   (TXD0),
    .rdy    (rdy),
    .ce_end (ce_end)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bit i of a word in transmission order, straight from the word-format rules.
  function automatic logic expBit(input logic [7:0] a, input logic [22:0] d, input logic pe, input int i);
    int ones;
    if (i < 8) return a[7-i];
    if (i < 31) return d[i-8];
    ones = $countones(a) + $countones(d);
    return ((ones % 2) == 0) ^ pe;
  endfunction

  function automatic logic [31:0] expWord(input logic [7:0] a, input logic [22:0] d, input logic pe);
    logic [31:0] w = '0;
    for (int i = 0; i < 32; i++) w = {w[30:0], expBit(a, d, pe, i)};
    return w;
  endfunction

  // Timeline model: mN counts clock edges since the accept edge while a word is in flight.
  logic        mBusy = 1'b0;
  int          mN = 0;
  int          accepts = 0;
  logic [7:0]  mAdr = '0;
  logic [22:0] mDat = '0;
  logic        mPe = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mBusy <= 1'b0;
      mN    <= 0;
    end else if (mBusy) begin
      if (mN == TOTAL) mBusy <= 1'b0;
      else mN <= mN + 1;
    end else if (st) begin
      mBusy   <= 1'b1;
      mN      <= 1;
      mAdr    <= in_adr;
      mDat    <= in_dat;
      mPe     <= par_err_s;
      accepts <= accepts + 1;
    end
  end

  // Every-cycle comparison of {TXD1,TXD0,rdy,ce_end} against the model.
  initial begin
    int p;
    logic b, hi;
    logic [3:0] exp;
    forever begin
      @(negedge clk);
      if (!mBusy) begin
        exp = 4'b0010;
      end else begin
        p = mN - 1;
        if (p < 32 * BITT) begin
          b   = expBit(mAdr, mDat, mPe, p / BITT);
          hi  = (p % BITT) < H;
          exp = {hi & b, hi & ~b, 2'b00};
        end else begin
          exp = {3'b000, p == TOTAL - 1};
        end
      end
      checkOutput("lines", {28'd0, TXD1, TXD0, rdy, ce_end}, {28'd0, exp});
    end
  end

  // Line decoder: recovers the bit sequence and measures pulse and null widths.
  logic [31:0] cap = '0;
  int          nbits = 0;
  int          hiCnt = 0;
  int          nullCnt = 0;
  int          lastNull = 0;
  int          ceCount = 0;
  logic        prevAny = 1'b0;
  logic        chkWidth = 1'b0;

  initial begin
    logic any;
    forever begin
      @(negedge clk);
      any = TXD1 | TXD0;
      if (mBusy && mN == 1) begin
        cap   = '0;
        nbits = 0;
      end
      if (ce_end) ceCount++;
      if (any && !prevAny) begin
        if (chkWidth && nbits > 0) checkOutput("null_w", 32'(nullCnt), 32'(H));
        cap      = {cap[30:0], TXD1};
        nbits++;
        lastNull = nullCnt;
      end
      if (!any && prevAny && chkWidth) checkOutput("pulse_w", 32'(hiCnt), 32'(H));
      if (any) begin
        hiCnt++;
        nullCnt = 0;
      end else begin
        nullCnt++;
        hiCnt = 0;
      end
      prevAny = any;
    end
  end

  task automatic applyStimulus(input logic [7:0] a, input logic [22:0] d, input logic pe);
    int n = 0;
    while (!rdy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!rdy) checkOutput("start_timeout", 32'(rdy), 32'd1);
    @(posedge clk);
    #3;
    in_adr    = a;
    in_dat    = d;
    par_err_s = pe;
    st        = 1'b1;
    @(posedge clk);
    #3;
    st     = 1'b0;
    in_adr = 8'($urandom);
    in_dat = 23'($urandom);
  endtask

  task automatic waitReady(output int n);
    n = 0;
    forever begin
      @(posedge clk);
      #1;
      n++;
      if (rdy || n >= 5000) break;
    end
    if (!rdy) checkOutput("ready_timeout", 32'(rdy), 32'd1);
  endtask

  task automatic directedWord(input string name, input logic [7:0] a, input logic [22:0] d,
                              input logic pe, input logic [31:0] word);
    int n, c0;
    c0 = ceCount;
    applyStimulus(a, d, pe);
    waitReady(n);
    checkOutput({name, "_occupancy"}, 32'(n), 32'(TOTAL));
    checkOutput({name, "_word"}, cap, word);
    checkOutput({name, "_nbits"}, 32'(nbits), 32'd32);
    checkOutput({name, "_ce_pulses"}, 32'(ceCount - c0), 32'd1);
  endtask

  initial begin
    int n, a0, t1, t2;
    logic [7:0]  ra;
    logic [22:0] rd;

    repeat (4) @(posedge clk);
    #1;
    checkOutput("reset", {28'd0, TXD1, TXD0, rdy, ce_end}, 32'b0010);
    @(posedge clk);
    #3;
    rst_n = 1'b1;

    // Hand-computed words: the parity bit lands in the last position.
    checkOutput("total_const", 32'(TOTAL), 32'd1800);
    directedWord("w01", 8'h01, 23'h0, 1'b0, 32'h0100_0000);
    directedWord("w03", 8'h03, 23'h0, 1'b0, 32'h0300_0001);
    chkWidth = 1'b1;
    directedWord("wA5", 8'hA5, 23'h7F_FFFF, 1'b0, 32'hA5FF_FFFE);
    chkWidth = 1'b0;

    // Strobe held high: the next word is taken the cycle rdy rises.
    a0 = accepts;
    t1 = 0;
    t2 = 0;
    n  = 0;
    @(posedge clk);
    #3;
    st = 1'b1;
    while (accepts < a0 + 2 && n < 5000) begin
      @(posedge clk);
      #3;
      n++;
      in_adr = 8'($urandom);
      in_dat = 23'($urandom);
      if (accepts == a0 + 1 && t1 == 0) t1 = n;
      if (accepts == a0 + 2) t2 = n;
    end
    st = 1'b0;
    checkOutput("b2b_accepts", 32'(accepts - a0), 32'd2);
    checkOutput("b2b_spacing", 32'(t2 - t1), 32'(TOTAL + 1));
    @(negedge clk);
    #1;
    // Null run between words: last LOW half, the full gap, then the single ready cycle.
    checkOutput("b2b_null", 32'(lastNull), 32'(H + GAP_BITS * BITT + 1));
    waitReady(n);

    // Reset in the middle of bit 10's HIGH half aborts the word at once.
    applyStimulus(8'($urandom), 23'($urandom), 1'b0);
    n = 0;
    while (!(mBusy && mN == 10 * BITT + 5) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("abort_reach", 32'(mN), 32'(10 * BITT + 5));
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("abort", {28'd0, TXD1, TXD0, rdy, ce_end}, 32'b0010);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;
    ra = 8'($urandom);
    rd = 23'($urandom);
    directedWord("post_rst", ra, rd, 1'b0, expWord(ra, rd, 1'b0));

`ifdef AR_TXD_PAR_ERR_EN
    directedWord("par_err", 8'h03, 23'h0, 1'b1, 32'h0300_0000);
`endif

    // Random traffic: strobes arrive at random, many while busy and therefore ignored.
    repeat (16000) begin
      @(posedge clk);
      #3;
      st     = ($urandom_range(0, 3) == 0);
      in_adr = 8'($urandom);
      in_dat = 23'($urandom);
`ifdef AR_TXD_PAR_ERR_EN
      par_err_s = 1'($urandom_range(0, 1));
`endif
    end
    st = 1'b0;
    waitReady(n);
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
